// File: rtl/conv_core_ctrl_if.sv
// Window-in and result-out valid/ready bundle of the convolution core sequencer.
// slave = the sequencer's view, master = the producer/consumer side.
interface conv_core_ctrl_if #(
  parameter int IMA   = 8,
  parameter int NUM   = 49,
  parameter int OUT_W = 39
);
  logic                 win_valid;
  logic                 win_ready;
  logic [IMA*NUM-1:0]   win_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_W-1:0]     res_data;

  modport master (output win_valid, win_data, res_ready,
                  input  win_ready, res_valid, res_data);
  modport slave  (input  win_valid, win_data, res_ready,
                  output win_ready, res_valid, res_data);
endinterface

// File: rtl/conv_core_ctrl.sv
// Sequencer for the 7x7 convolution core: weight/bias bank, credit-throttled
// window issue, and a show-ahead result FIFO that can never be overrun.
module conv_core_ctrl #(
  parameter int DATA  = 16,
  parameter int IMA   = 8,
  parameter int NUM   = 49,
  parameter int OUT_W = 39,
  parameter int RBUF  = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [5:0]           cfg_addr,
  input  logic [DATA-1:0]      cfg_data,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_px,
  conv_core_ctrl_if.slave      bus,
  output logic                 core_enable,
  output logic [IMA*NUM-1:0]   core_ima,
  output logic [DATA*NUM-1:0]  core_wei,
  output logic [DATA-1:0]      core_bias,
  input  logic                 core_valid,
  input  logic [OUT_W-1:0]     core_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf
);
  localparam int PTR_W = $clog2(RBUF);
  localparam int WB_W  = $clog2(DATA*NUM);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      num_r, issued_r, popped_r;
  logic [PTR_W:0]        occ_r, wr_ptr_r, rd_ptr_r;
  logic [OUT_W-1:0]      mem_r [RBUF];
  logic [IMA*NUM-1:0]    core_ima_r;
  logic [DATA*NUM-1:0]   wei_r;
  logic [DATA-1:0]       bias_r;
  logic                  core_enable_r, busy_r, done_r, err_ovf_r;
  logic                  win_ready_s, win_hs_s, pop_s, push_s, full_s, empty_s;
  logic [WB_W-1:0]       wei_base_s;

  // occ counts every window not yet popped, so the FIFO always has room for it
  assign win_ready_s = (state_r == RUN) && (issued_r < num_r) && (occ_r < (PTR_W+1)'(RBUF));
  assign win_hs_s    = bus.win_valid && win_ready_s;
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_s       = !empty_s && bus.res_ready;
  assign push_s      = core_valid && (!full_s || pop_s);
  assign wei_base_s  = WB_W'(cfg_addr) * WB_W'(DATA);

  assign bus.win_ready = win_ready_s;
  assign bus.res_valid = !empty_s;
  assign bus.res_data  = empty_s ? {OUT_W{1'b0}} : mem_r[rd_ptr_r[PTR_W-1:0]];
  assign core_enable   = core_enable_r;
  assign core_ima      = core_ima_r;
  assign core_wei      = wei_r;
  assign core_bias     = bias_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_ovf       = err_ovf_r;

  // Job sequencing next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (num_px == CNT_W'(0)) state_s = DONE;
          else                     state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (win_hs_s && ((issued_r + CNT_W'(1)) == num_r)) state_s = DRAIN;
        else                                               state_s = RUN;
      end
      DRAIN: begin
        if (popped_r == num_r) state_s = DONE;
        else                   state_s = DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with busy/done decoded ahead so they leave a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Job length and progress counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r    <= CNT_W'(0);
      issued_r <= CNT_W'(0);
      popped_r <= CNT_W'(0);
    end else if (state_r == IDLE && start) begin
      num_r    <= num_px;
      issued_r <= CNT_W'(0);
      popped_r <= CNT_W'(0);
    end else begin
      if (win_hs_s) issued_r <= issued_r + CNT_W'(1);
      if (pop_s)    popped_r <= popped_r + CNT_W'(1);
    end
  end

  // Occupancy credit: issued windows minus popped results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= (PTR_W+1)'(0);
    end else begin
      case ({win_hs_s, pop_s})
        2'b10:   occ_r <= occ_r + (PTR_W+1)'(1);
        2'b01:   occ_r <= occ_r - (PTR_W+1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Window issue register and one-cycle core enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_enable_r <= 1'b0;
      core_ima_r    <= {(IMA*NUM){1'b0}};
    end else begin
      core_enable_r <= win_hs_s;
      if (win_hs_s) core_ima_r <= bus.win_data;
    end
  end

  // Weight/bias bank, writable only between jobs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wei_r  <= {(DATA*NUM){1'b0}};
      bias_r <= {DATA{1'b0}};
    end else if (state_r == IDLE && cfg_wr) begin
      if (cfg_addr < 6'(NUM))       wei_r[wei_base_s +: DATA] <= cfg_data;
      else if (cfg_addr == 6'(NUM)) bias_r <= cfg_data;
    end
  end

  // Result FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= (PTR_W+1)'(0);
      rd_ptr_r  <= (PTR_W+1)'(0);
      err_ovf_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      if (core_valid && full_s && !pop_s) err_ovf_r <= 1'b1;
    end
  end

  // Result storage; contents are masked by the pointers so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[PTR_W-1:0]] <= core_out;
  end
endmodule

// File: tb/tb_conv_core_ctrl.sv
// Randomized bench for conv_core_ctrl: a job-level model plus a latency-8 core
// model, compared against the DUT every cycle at the falling edge.
module tb_conv_core_ctrl;
  localparam int DATA = 16, IMA = 8, NUM = 49, OUT_W = 39, RBUF = 8, CNT_W = 16, LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_wr = 1'b0;
  logic [5:0] cfg_addr = 6'd0;
  logic [DATA-1:0] cfg_data = 16'd0;
  logic start = 1'b0;
  logic [CNT_W-1:0] num_px = 16'd0;
  logic core_enable, busy, done, err_ovf;
  logic [IMA*NUM-1:0] core_ima;
  logic [DATA*NUM-1:0] core_wei;
  logic [DATA-1:0] core_bias;
  logic core_valid = 1'b0;
  logic [OUT_W-1:0] core_out = 39'd0;

  conv_core_ctrl_if #(.IMA(IMA), .NUM(NUM), .OUT_W(OUT_W)) bus ();

  conv_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_px(num_px), .bus(bus), .core_enable(core_enable),
    .core_ima(core_ima), .core_wei(core_wei), .core_bias(core_bias),
    .core_valid(core_valid), .core_out(core_out), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // convolution as the core performs it: bias + sum of pixel*weight
  function automatic logic [OUT_W-1:0] conv(input logic [IMA*NUM-1:0] px,
                                            input logic [DATA*NUM-1:0] wt,
                                            input logic [DATA-1:0] b);
    longint s;
    s = longint'(b);
    for (int k = 0; k < NUM; k++)
      s += longint'(px[k*IMA +: IMA]) * longint'(wt[k*DATA +: DATA]);
    return OUT_W'(s);
  endfunction

  // model: job phase 0 idle, 1 issuing, 2 draining, 3 done
  int m_phase = 0, m_num = 0, m_issued = 0, m_popped = 0, m_occ = 0;
  bit m_en = 1'b0, m_err = 1'b0;
  logic [DATA*NUM-1:0] m_wei = '0;
  logic [DATA-1:0] m_bias = '0;
  logic [OUT_W-1:0] m_fifo[$];
  logic [OUT_W-1:0] exp_q[$];
  logic pipe_v[LAT];
  logic [OUT_W-1:0] pipe_d[LAT];
  bit inj = 1'b0, rnd_win = 1'b0, rnd_hs = 1'b0;
  int en_cnt = 0, done_cnt = 0, pop_cnt = 0;
  logic [OUT_W-1:0] last_pop = '0;

  always @(negedge clk) begin
    bit hs, pop, ev, exp_wr;
    int old_phase;
    logic [OUT_W-1:0] hd, want;
    if (!rst_n) begin
      m_phase = 0; m_num = 0; m_issued = 0; m_popped = 0; m_occ = 0;
      m_en = 1'b0; m_err = 1'b0; m_wei = '0; m_bias = '0;
      m_fifo.delete(); exp_q.delete();
      for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
      core_valid = 1'b0; core_out = '0;
    end
    ev = (m_fifo.size() > 0);
    hd = ev ? m_fifo[0] : '0;
    exp_wr = (m_phase == 1) && (m_issued < m_num) && (m_occ < RBUF);
    chk("win_ready", 64'(bus.win_ready), 64'(exp_wr));
    chk("core_enable", 64'(core_enable), 64'(m_en));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("done", 64'(done), 64'(m_phase == 3));
    chk("res_valid", 64'(bus.res_valid), 64'(ev));
    chk("res_data", 64'(bus.res_data), 64'(hd));
    chk("err_ovf", 64'(err_ovf), 64'(m_err));
    chk("core_bias", 64'(core_bias), 64'(m_bias));
    for (int k = 0; k < NUM; k++)
      chk("core_wei_tap", 64'(core_wei[k*DATA +: DATA]), 64'(m_wei[k*DATA +: DATA]));
    if (rst_n) begin
      if (core_enable) en_cnt++;
      if (done) done_cnt++;
      for (int i = LAT-1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_d[i] = pipe_d[i-1]; end
      pipe_v[0] = core_enable;
      pipe_d[0] = conv(core_ima, core_wei, core_bias);
      core_valid = pipe_v[LAT-1] | inj;
      core_out   = pipe_v[LAT-1] ? pipe_d[LAT-1] : OUT_W'({$urandom, $urandom});
      hs  = exp_wr && bus.win_valid;
      pop = ev && bus.res_ready;
      old_phase = m_phase;
      case (m_phase)
        0: if (start) begin
             m_num = int'(num_px); m_issued = 0; m_popped = 0;
             m_phase = (num_px == 16'd0) ? 3 : 1;
           end
        1: if (hs && (m_issued + 1 == m_num)) m_phase = 2;
        2: if (m_popped == m_num) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (hs) begin
        exp_q.push_back(conv(bus.win_data, m_wei, m_bias));
        m_issued++; m_occ++;
      end
      if (pop) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~hd;
        chk("result_order", 64'(hd), 64'(want));
        m_occ--; m_popped++; pop_cnt++; last_pop = hd;
        void'(m_fifo.pop_front());
      end
      if (core_valid) begin
        if (m_fifo.size() < RBUF) m_fifo.push_back(core_out);
        else m_err = 1'b1;
      end
      if (old_phase == 0 && cfg_wr) begin
        if (cfg_addr < 6'd49) m_wei[int'(cfg_addr)*DATA +: DATA] = cfg_data;
        else if (cfg_addr == 6'd49) m_bias = cfg_data;
      end
      m_en = hs;
    end
  end

  task automatic rand_win();
    for (int k = 0; k < NUM; k++) bus.win_data[k*IMA +: IMA] = IMA'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_win) rand_win();
    if (rnd_hs) begin
      bus.win_valid = 1'($urandom);
      bus.res_ready = 1'($urandom);
    end
  endtask

  task automatic cfg(input logic [5:0] a, input logic [DATA-1:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic go(input logic [CNT_W-1:0] n);
    start = 1'b1; num_px = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, c;
    d0 = done_cnt; c = 0;
    while (done_cnt == d0 && c < budget) begin tick(); c++; end
    chk({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p0, c;
    bus.win_valid = 1'b0; bus.res_ready = 1'b0; bus.win_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // config bank, ignored address 55
    for (int k = 0; k < NUM; k++) cfg(6'(k), 16'(k + 1));
    cfg(6'd49, 16'h0100);
    cfg(6'd55, 16'hBEEF);
    chk("cfg_tap0", 64'(core_wei[15:0]), 64'd1);
    chk("cfg_tap48", 64'(core_wei[783:768]), 64'd49);
    chk("cfg_bias", 64'(core_bias), 64'h0100);

    // single pixel, all window pixels 0x01
    for (int k = 0; k < NUM; k++) bus.win_data[k*IMA +: IMA] = 8'h01;
    bus.win_valid = 1'b1; bus.res_ready = 1'b1;
    e0 = en_cnt;
    go(16'd1);
    wait_done("single", 100);
    chk("single_enables", 64'(en_cnt - e0), 64'd1);
    chk("single_result", 64'(last_pop), 64'd1481);
    chk("single_busy_after", 64'(busy), 64'd0);

    // 20-pixel stream, cfg write during the job must be ignored
    rnd_win = 1'b1; rand_win();
    e0 = en_cnt; p0 = pop_cnt;
    go(16'd20);
    cfg(6'd0, 16'hFFFF);
    wait_done("stream", 300);
    chk("stream_enables", 64'(en_cnt - e0), 64'd20);
    chk("stream_pops", 64'(pop_cnt - p0), 64'd20);
    chk("stream_tap0_kept", 64'(core_wei[15:0]), 64'd1);

    // empty job
    e0 = en_cnt;
    go(16'd0);
    chk("zero_done", 64'(done), 64'd1);
    tick();
    chk("zero_done_gone", 64'(done), 64'd0);
    chk("zero_enables", 64'(en_cnt - e0), 64'd0);
    chk("zero_res_valid", 64'(bus.res_valid), 64'd0);

    // backpressure, ignored restart, forced overflow
    bus.res_ready = 1'b0;
    e0 = en_cnt; p0 = pop_cnt;
    go(16'd20);
    repeat (30) tick();
    chk("bp_win_ready", 64'(bus.win_ready), 64'd0);
    chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
    chk("bp_issued", 64'(en_cnt - e0), 64'd8);
    chk("bp_err_clear", 64'(err_ovf), 64'd0);
    start = 1'b1; num_px = 16'd5;
    tick();
    start = 1'b0;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick(); tick();
    chk("ovf_set", 64'(err_ovf), 64'd1);
    bus.res_ready = 1'b1;
    wait_done("bp", 400);
    chk("bp_enables", 64'(en_cnt - e0), 64'd20);
    chk("bp_pops", 64'(pop_cnt - p0), 64'd20);

    // random handshakes on a random-length job
    rnd_hs = 1'b1;
    p0 = pop_cnt;
    c = $urandom_range(10, 40);
    go(16'(c));
    wait_done("rand", 3000);
    chk("rand_pops", 64'(pop_cnt - p0), 64'(c));
    rnd_hs = 1'b0;
    bus.win_valid = 1'b1; bus.res_ready = 1'b1;
    tick();

    // asynchronous reset in the middle of a job
    e0 = en_cnt;
    go(16'd20);
    c = 0;
    while (en_cnt - e0 < 5 && c < 100) begin tick(); c++; end
    chk("pre_reset_issues", 64'(en_cnt - e0 >= 5), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_enable", 64'(core_enable), 64'd0);
    chk("ar_ima_zero", 64'(core_ima == '0), 64'd1);
    chk("ar_wei_zero", 64'(core_wei == '0), 64'd1);
    chk("ar_bias", 64'(core_bias), 64'd0);
    chk("ar_win_ready", 64'(bus.win_ready), 64'd0);
    chk("ar_res_valid", 64'(bus.res_valid), 64'd0);
    chk("ar_res_data", 64'(bus.res_data), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_err", 64'(err_ovf), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(); tick();
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_wei", 64'(core_wei == '0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
